can_rx_packer: RTL and testbench
================================

CAN_RX_PACKER -- requirements
Module: can_rx_packer

Interface
REQ-001 Parameter DEPTH_LOG2, default 2, log2 of the frame FIFO depth (4 frames).
REQ-002 Parameter CNT_W, default 16, width of the drop counter.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 clk  input  1  clock; all logic is on its rising edge.
REQ-005 in_valid  input  1  byte strobe from the CAN RX byte stream; the input has no backpressure.
REQ-006 in_last  input  1  qualifies in_valid; marks the final byte of a packet.
REQ-007 in_data  input  8  payload byte; the first byte of a packet arrives first.
REQ-008 in_id  input  29  packet ID; stable from the first byte through the last byte.
REQ-009 in_ide  input  1  1 = 29-bit ID, 0 = 11-bit ID; stable like in_id.
REQ-010 out_valid  output  1  FIFO head frame is available.
REQ-011 out_ready  input  1  consumer accepts the head frame.
REQ-012 out_data  output  64  payload; byte 0 in [63:56], byte n in [63-8n -: 8]; unused bytes are 0.
REQ-013 out_len  output  4  byte count, 1..8.
REQ-014 out_id  output  29  ID of the head frame.
REQ-015 out_ide  output  1  IDE of the head frame.
REQ-016 drop_cnt  output  CNT_W  count of dropped frames; saturates at all-ones.
REQ-017 err_ovf  output  1  one-cycle pulse when a frame is aborted for exceeding 8 bytes.

Function
REQ-018 The assembler SHALL use two states, IDLE and COLLECT, plus DISCARD for aborted frames.
REQ-019 IDLE, in_valid & ~in_last: clear the assembly register, store the byte in slot 0, set count = 1, latch in_id/in_ide, go to COLLECT.
REQ-020 IDLE, in_valid & in_last: treat as a complete 1-byte frame, perform the commit (REQ-023), stay in IDLE.
REQ-021 COLLECT, in_valid with count < 8: store the byte in slot[count] and increment count; if in_last, commit and return to IDLE.
REQ-022 COLLECT, in_valid with count == 8 (9th byte): pulse err_ovf, discard the partial frame, increment drop_cnt, and go to DISCARD; if that byte has in_last, go to IDLE instead.
REQ-023 Commit: push {data, len = count, id, ide} to the FIFO in the cycle after the last byte; out_valid rises in that same cycle.
REQ-024 A commit SHALL be accepted if the FIFO is not full, or if it is full and out_valid & out_ready pop in the same cycle; otherwise drop the frame and increment drop_cnt.
REQ-025 DISCARD: ignore bytes until an in_valid & in_last byte, then go to IDLE; that byte is also ignored.
REQ-026 The FIFO SHALL hold 2**DEPTH_LOG2 frames, be first-word-fall-through, and use pointers DEPTH_LOG2+1 bits wide that wrap naturally; full when the MSBs differ and the low bits are equal.
REQ-027 out_valid = FIFO not empty; a pop occurs on out_valid & out_ready; out_* is stable while out_valid & ~out_ready.
REQ-028 out_ready while empty SHALL have no effect.
REQ-029 in_last without in_valid SHALL be ignored.
REQ-030 in_id/in_ide changes mid-packet SHALL be ignored; the first-byte values are used.
REQ-031 drop_cnt SHALL increment by at most 1 per cycle and SHALL hold at 2**CNT_W-1.

Reset
REQ-032 rstn low SHALL asynchronously force: state IDLE, count 0, FIFO pointers 0, out_valid 0, drop_cnt 0, err_ovf 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; FIFO contents are lost and nothing is committed.
REQ-034 out_data/out_len/out_id/out_ide are don't-care while out_valid = 0; frame storage needs no reset.

Verification
REQ-035 Bytes 11,22,33 (last on 33), id 0x123, ide 0, out_ready 1 -> next cycle out_valid=1, out_len=3, out_data=0x1122330000000000, out_id=0x123.
REQ-036 Five 1-byte frames with out_ready 0 -> first four stored, fifth dropped, drop_cnt=1, out_valid held; then out_ready 1 -> four frames in order.
REQ-037 Ten bytes with last on the 10th -> err_ovf pulses once at the 9th byte, drop_cnt=1, no frame output, next packet assembles normally.
REQ-038 FIFO full and a commit in the same cycle as a pop -> commit accepted, drop_cnt unchanged, occupancy stays 4.
REQ-039 rstn pulsed after 4 of 8 bytes, remaining bytes continue -> no frame output; the following clean packet is received correctly.
REQ-040 Eight-byte frame with ide=1, id=0x12345678 -> out_len=8, full 64-bit payload, out_ide=1; then 20 cycles of continuous back-to-back traffic verify pointer wrap.

Source files
------------

// File: rtl/can_rx_packer.sv
// Packs a CAN RX byte stream into frames of 1..8 bytes and queues them in a small
// first-word-fall-through FIFO. Oversized frames and frames arriving while the FIFO is full are counted as drops.
module can_rx_packer #(
  parameter int DEPTH_LOG2 = 2,
  parameter int CNT_W      = 16
) (
  input  logic             rstn,
  input  logic             clk,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [7:0]       in_data,
  input  logic [28:0]      in_id,
  input  logic             in_ide,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [3:0]       out_len,
  output logic [28:0]      out_id,
  output logic             out_ide,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             err_ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count, count_nxt;
  logic [63:0] asm_data, asm_data_nxt;
  logic [28:0] asm_id, asm_id_nxt;
  logic        asm_ide, asm_ide_nxt;

  logic        commit, ovf;
  logic [63:0] commit_data;
  logic [3:0]  commit_len;
  logic [28:0] commit_id;
  logic        commit_ide;
  logic [63:0] byte_at_slot;

  // The assembly register is cleared at frame start, so ORing in the new byte fills slot[count].
  assign byte_at_slot = {in_data, 56'b0} >> {count[2:0], 3'b000};

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    asm_data_nxt = asm_data;
    asm_id_nxt   = asm_id;
    asm_ide_nxt  = asm_ide;
    commit       = 1'b0;
    ovf          = 1'b0;
    commit_data  = asm_data | byte_at_slot;
    commit_len   = count + 4'd1;
    commit_id    = asm_id;
    commit_ide   = asm_ide;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          commit_data = {in_data, 56'b0};
          commit_len  = 4'd1;
          commit_id   = in_id;
          commit_ide  = in_ide;
          if (in_last) begin
            commit = 1'b1;
          end else begin
            asm_data_nxt = {in_data, 56'b0};
            asm_id_nxt   = in_id;
            asm_ide_nxt  = in_ide;
            count_nxt    = 4'd1;
            state_nxt    = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (count == 4'd8) begin
            ovf       = 1'b1;
            count_nxt = 4'd0;
            state_nxt = in_last ? IDLE : DISCARD;
          end else begin
            asm_data_nxt = commit_data;
            count_nxt    = count + 4'd1;
            if (in_last) begin
              commit    = 1'b1;
              count_nxt = 4'd0;
              state_nxt = IDLE;
            end
          end
        end
      end
      DISCARD: begin
        if (in_valid && in_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame FIFO: one extra pointer bit distinguishes full from empty.
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                full, empty, pop, push, drop_inc;

  logic [63:0] mem_data [DEPTH];
  logic [3:0]  mem_len  [DEPTH];
  logic [28:0] mem_id   [DEPTH];
  logic        mem_ide  [DEPTH];

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign out_valid = ~empty;
  assign pop      = out_valid & out_ready;
  assign push     = commit & (~full | pop);
  assign drop_inc = ovf | (commit & ~push);

  assign out_data = mem_data[rd_ptr[DEPTH_LOG2-1:0]];
  assign out_len  = mem_len[rd_ptr[DEPTH_LOG2-1:0]];
  assign out_id   = mem_id[rd_ptr[DEPTH_LOG2-1:0]];
  assign out_ide  = mem_ide[rd_ptr[DEPTH_LOG2-1:0]];

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      count    <= 4'd0;
      asm_data <= 64'd0;
      asm_id   <= 29'd0;
      asm_ide  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
      err_ovf  <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      asm_data <= asm_data_nxt;
      asm_id   <= asm_id_nxt;
      asm_ide  <= asm_ide_nxt;
      err_ovf  <= ovf;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop_inc && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // NOTE: frame storage has no reset; its contents only matter behind out_valid, which the pointers already clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[DEPTH_LOG2-1:0]] <= commit_data;
      mem_len[wr_ptr[DEPTH_LOG2-1:0]]  <= commit_len;
      mem_id[wr_ptr[DEPTH_LOG2-1:0]]   <= commit_id;
      mem_ide[wr_ptr[DEPTH_LOG2-1:0]]  <= commit_ide;
    end
  end

endmodule

// File: tb/tb_can_rx_packer.sv
// Testbench for can_rx_packer: directed scenarios plus random traffic, checked every cycle
// against a packet-level reference model built from byte queues and a frame queue.
module tb_can_rx_packer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, in_ide = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic [28:0] in_id = 29'd0;
  logic        out_valid, out_ide, err_ovf;
  logic [63:0] out_data;
  logic [3:0]  out_len;
  logic [28:0] out_id;
  logic [15:0] drop_cnt;

  can_rx_packer #(.DEPTH_LOG2(2), .CNT_W(16)) dut (
    .rstn(rstn), .clk(clk),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_id(in_id), .in_ide(in_ide),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len),
    .out_id(out_id), .out_ide(out_ide), .drop_cnt(drop_cnt), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  len;
    logic [28:0] id;
    logic        ide;
  } frame_t;

  // Reference model: frames waiting for the consumer, bytes of the packet in progress.
  frame_t      fq[$];
  logic [7:0]  pkt[$];
  bit          discarding = 1'b0;
  logic [28:0] m_id = '0;
  logic        m_ide = 1'b0;
  int unsigned m_drop = 0;
  bit          m_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic count_drop();
    if (m_drop < 65535) m_drop++;
  endtask

  // Applies the sampled inputs of one rising edge to the model.
  task automatic model_edge();
    frame_t f;
    bit     have, pop;
    int     occ;
    if (!rstn) begin
      fq.delete(); pkt.delete();
      discarding = 1'b0; m_drop = 0; m_ovf = 1'b0;
      return;
    end
    have  = 1'b0;
    m_ovf = 1'b0;
    occ   = fq.size();
    pop   = (occ > 0) && out_ready;
    if (in_valid) begin
      if (discarding) begin
        if (in_last) discarding = 1'b0;
      end else if (pkt.size() == 8) begin
        m_ovf = 1'b1;
        count_drop();
        pkt.delete();
        discarding = !in_last;
      end else begin
        if (pkt.size() == 0) begin
          m_id = in_id; m_ide = in_ide;
        end
        pkt.push_back(in_data);
        if (in_last) begin
          f.data = 64'd0;
          foreach (pkt[i]) f.data[63-8*i -: 8] = pkt[i];
          f.len = 4'(pkt.size());
          f.id  = m_id;
          f.ide = m_ide;
          have  = 1'b1;
          pkt.delete();
        end
      end
    end
    if (pop) void'(fq.pop_front());
    if (have) begin
      if (occ < 4 || pop) fq.push_back(f);
      else count_drop();
    end
  endtask

  task automatic compare();
    check("out_valid", out_valid, 64'(fq.size() > 0));
    if (fq.size() > 0) begin
      check("out_data", out_data, fq[0].data);
      check("out_len", out_len, fq[0].len);
      check("out_id", out_id, fq[0].id);
      check("out_ide", out_ide, fq[0].ide);
    end
    check("drop_cnt", drop_cnt, m_drop);
    check("err_ovf", err_ovf, m_ovf);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input bit v, input bit l, input logic [7:0] d,
                       input logic [28:0] id, input bit ide, input bit rdy);
    in_valid = v; in_last = l; in_data = d; in_id = id; in_ide = ide; out_ready = rdy;
    cycle();
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 1'b0, 8'h00, 29'd0, 1'b0, rdy);
  endtask

  initial begin
    int          pulses;
    int          occupancy;
    logic [7:0]  b;
    logic [63:0] exp8;

    // Reset state.
    cycle();
    cycle();
    check("reset_out_valid", out_valid, 64'd0);
    check("reset_drop_cnt", drop_cnt, 64'd0);
    rstn = 1'b1;
    idle(1'b0);

    // Three-byte frame.
    drive(1, 0, 8'h11, 29'h123, 0, 1);
    drive(1, 0, 8'h22, 29'h123, 0, 1);
    drive(1, 1, 8'h33, 29'h123, 0, 1);
    check("r035_valid", out_valid, 64'd1);
    check("r035_data", out_data, 64'h1122330000000000);
    check("r035_len", out_len, 64'd3);
    check("r035_id", out_id, 64'h123);
    idle(1'b1);

    // Five single-byte frames with no consumer: the fifth is dropped.
    for (int i = 0; i < 5; i++) drive(1, 1, 8'(8'hA0 + i), 29'(i), 1'(i), 0);
    check("r036_drop", drop_cnt, 64'd1);
    check("r036_valid_held", out_valid, 64'd1);
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'hA0 + i);
      check("r036_order", out_data, {b, 56'd0});
      idle(1'b1);
    end
    check("r036_empty", out_valid, 64'd0);

    // Ten-byte packet: overflow at the ninth byte, tenth byte ends the discard.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, (i == 9), 8'(i), 29'h55, 0, 1);
      if (err_ovf) pulses++;
    end
    idle(1'b1);
    if (err_ovf) pulses++;
    check("r037_pulses", 64'(pulses), 64'd1);
    check("r037_drop", drop_cnt, 64'd2);
    drive(1, 0, 8'hC1, 29'h0AB, 1, 1);
    drive(1, 1, 8'hC2, 29'h1FFFFFFF, 0, 1);
    check("r037_next_data", out_data, 64'hC1C2000000000000);
    check("r037_next_id", out_id, 64'h0AB);
    idle(1'b1);

    // Full FIFO; commit lands in the same cycle as a pop.
    for (int i = 0; i < 4; i++) drive(1, 1, 8'(8'h10 + i), 29'(i), 0, 0);
    drive(1, 0, 8'hE0, 29'h7, 0, 0);
    drive(1, 1, 8'hE1, 29'h7, 0, 1);
    check("r038_drop", drop_cnt, 64'd2);
    occupancy = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) occupancy++;
      idle(1'b1);
    end
    check("r038_occupancy", 64'(occupancy), 64'd4);

    // Reset partway through an eight-byte packet; the rest of it arrives while reset is held.
    for (int i = 0; i < 4; i++) drive(1, 0, 8'(8'h40 + i), 29'h99, 0, 1);
    rstn = 1'b0;
    #1;
    check("r039_async_valid", out_valid, 64'd0);
    check("r039_async_drop", drop_cnt, 64'd0);
    for (int i = 4; i < 8; i++) drive(1, (i == 7), 8'(8'h40 + i), 29'h99, 0, 1);
    rstn = 1'b1;
    idle(1'b1);
    idle(1'b1);
    check("r039_no_frame", out_valid, 64'd0);
    drive(1, 0, 8'h5A, 29'h321, 0, 0);
    drive(1, 1, 8'hA5, 29'h321, 0, 0);
    check("r039_clean_data", out_data, 64'h5AA5000000000000);
    idle(1'b1);

    // Full eight-byte extended-ID frame.
    for (int i = 0; i < 8; i++) drive(1, (i == 7), 8'(i + 1), 29'h12345678, 1, 1);
    exp8 = 64'h0102030405060708;
    check("r040_data", out_data, exp8);
    check("r040_len", out_len, 64'd8);
    check("r040_ide", out_ide, 64'd1);
    check("r040_id", out_id, 64'h12345678);

    // Back-to-back traffic across pointer wrap.
    for (int i = 0; i < 20; i++)
      drive(1, ($urandom_range(0, 2) == 0), 8'($urandom), 29'($urandom), 1'($urandom), 1);

    // Random traffic including overflows, stalls and drops.
    for (int i = 0; i < 600; i++)
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), 8'($urandom),
            29'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));

    for (int i = 0; i < 8; i++) idle(1'b1);
    check("final_empty", out_valid, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
